// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the serial FFT stream.
// Each N-point frame arrives in bit-reversed order and leaves in natural
// order. Two banks ping-pong: the writer fills one while the reader drains
// the other through a valid/ready handshake. Sticky flags report frames
// dropped for lack of a free bank and frames restarted mid-way.
module fft_out_reorder #(
    parameter int N     = 16,
    parameter int LOG2N = 4,
    parameter int DW    = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_first,
    output logic          out_last,
    output logic          err_overflow,
    output logic          err_resync
);

    typedef enum logic [1:0] {W_WAIT, W_FILL, W_DROP} wstate_t;
    typedef enum logic       {R_IDLE, R_STREAM}       rstate_t;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    // Sample storage: bank index first, then address within the frame.
    logic [DW-1:0] mem [0:1][0:N-1];

    // Writer state
    wstate_t          wstate;
    logic [LOG2N-1:0] wptr;
    logic             wbank;

    // Reader state
    rstate_t          rstate;
    logic [LOG2N-1:0] rcnt;
    logic [LOG2N-1:0] rcnt_nxt;
    logic             rbank;

    // Per-bank "holds a complete frame" flags
    logic [1:0] full;
    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    // Decoded writer actions for this cycle
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_done;

    // Reader releases its bank on this edge
    logic rd_free;
    logic free_cur;
    logic free_oth;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign rcnt_nxt = rcnt + ONE;
    assign rd_free  = (rstate == R_STREAM) && out_ready && (rcnt == LAST);

    // A bank counts as free if it is empty now or the reader empties it on
    // this very edge, which is what lets back-to-back frames run bubble-free.
    assign free_cur = !full[wbank]  || (rd_free && (rbank == wbank));
    assign free_oth = !full[~wbank] || (rd_free && (rbank != wbank));

    // Decode whether the incoming sample is stored, where, and whether it
    // completes the frame.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        wr_en   = 1'b0;
        wr_addr = wptr;
        wr_done = 1'b0;
        case (wstate)
            W_WAIT, W_DROP: begin
                if (in_valid && in_first && free_cur) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    if (in_first) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                    end else if (wptr != '0) begin
                        wr_en   = 1'b1;
                        wr_done = (wptr == LAST);
                    end
                end
            end
            default: ;
        endcase
    end

    // Store incoming samples at their bit-reversed arrival position.
    // NOTE: the sample memory has no reset; its contents are never observed
    // before being written, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wbank][wr_addr] <= in_data;
        end
    end

    // Writer FSM: frame alignment, bank switching, sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            wstate       <= W_WAIT;
            wptr         <= '0;
            wbank        <= 1'b0;
            err_overflow <= 1'b0;
            err_resync   <= 1'b0;
        end else begin
            case (wstate)
                W_WAIT, W_DROP: begin
                    if (in_valid && in_first) begin
                        if (free_cur) begin
                            wptr   <= ONE;
                            wstate <= W_FILL;
                        end else begin
                            wstate       <= W_DROP;
                            err_overflow <= 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    if (in_valid) begin
                        if (in_first) begin
                            // Restart: anything already in this bank is overwritten.
                            if (wptr != '0) begin
                                err_resync <= 1'b1;
                            end
                            wptr <= ONE;
                        end else if (wptr == '0) begin
                            // A frame must begin with in_first; resynchronise.
                            err_resync <= 1'b1;
                            wstate     <= W_WAIT;
                        end else if (wptr == LAST) begin
                            wptr  <= '0;
                            wbank <= ~wbank;
                            if (!free_oth) begin
                                wstate <= W_WAIT;
                            end
                        end else begin
                            wptr <= wptr + ONE;
                        end
                    end
                end
                default: wstate <= W_WAIT;
            endcase
        end
    end

    assign set_mask = wr_done ? (2'b01 << wbank) : 2'b00;
    assign clr_mask = rd_free ? (2'b01 << rbank) : 2'b00;

    // Bank occupancy: set by the writer on the last sample, cleared by the
    // reader on the last transfer. The two never target the same bank at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~clr_mask) | set_mask;
        end
    end

    // Reader FSM: drains full banks in fill order with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate    <= R_IDLE;
            rcnt      <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (full[rbank]) begin
                        rstate    <= R_STREAM;
                        rcnt      <= '0;
                        out_valid <= 1'b1;
                        out_data  <= mem[rbank][0];
                        out_first <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                R_STREAM: begin
                    if (out_ready) begin
                        if (rcnt == LAST) begin
                            rbank <= ~rbank;
                            rcnt  <= '0;
                            if (full[~rbank]) begin
                                // Next frame is ready: continue without a bubble.
                                out_data  <= mem[~rbank][0];
                                out_first <= 1'b1;
                                out_last  <= 1'b0;
                            end else begin
                                rstate    <= R_IDLE;
                                out_valid <= 1'b0;
                                out_first <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            rcnt      <= rcnt_nxt;
                            out_data  <= mem[rbank][bitrev(rcnt_nxt)];
                            out_first <= 1'b0;
                            out_last  <= (rcnt_nxt == LAST);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder (N=16): reset, single frame, back-to-back
// frames, output stalls, overflow, resync and reset during drain.
module tb_fft_out_reorder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_first;
    logic [33:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [33:0] out_data;
    logic        out_first;
    logic        out_last;
    logic        err_overflow;
    logic        err_resync;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    // Natural output index j reads the sample that arrived at position br[j].
    int br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_out_reorder #(.N(16), .LOG2N(4), .DW(34)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_data      (in_data),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_first    (out_first),
        .out_last     (out_last),
        .err_overflow (err_overflow),
        .err_resync   (err_resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample payload: frame tag and input position, with bit 33 set.
    function automatic logic [33:0] mk(input int f, input int k);
        return {2'b10, f[23:0], k[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send n contiguous samples of frame f, in_first on the first one.
    task automatic send(input int f, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_first = (k == 0);
            in_data  = mk(f, k);
            tick();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_frames(input int f0, input int nfr);
        for (int i = 0; i < nfr; i++) begin
            send(f0 + i, 16);
        end
    endtask

    // Collect nfr frames starting at frame tag f0, checking every valid cycle.
    // With stall set, out_ready follows 1,0,0,1. cycles counts from the first
    // valid cycle to the last transfer.
    task automatic recv(input int f0, input int nfr, input bit stall, output int cycles);
        int beat;
        int guard;
        int st;
        int j;
        beat   = 0;
        guard  = 0;
        st     = 0;
        cycles = 0;
        while (beat < nfr * 16 && guard < 4000) begin
            out_ready = stall ? ((st % 4) == 0 || (st % 4) == 3) : 1'b1;
            st++;
            if (out_valid) begin
                j = beat % 16;
                check($sformatf("out_data[%0d]", beat), out_data, mk(f0 + beat / 16, br[j]));
                check($sformatf("out_first[%0d]", beat), out_first, j == 0);
                check($sformatf("out_last[%0d]", beat), out_last, j == 15);
                if (out_ready) beat++;
            end
            if (beat > 0 || out_valid) cycles++;
            tick();
            guard++;
        end
        check("recv_beats", beat, nfr * 16);
        out_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_resync", err_resync, 0);
        rst_n = 1'b1;
        tick();

        // Samples without a frame start are ignored
        in_valid = 1'b1;
        in_first = 1'b0;
        in_data  = mk(99, 1);
        repeat (5) begin
            tick();
            check("noframe_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        check("noframe_overflow", err_overflow, 0);
        check("noframe_resync", err_resync, 0);

        // Single frame, first out_valid one cycle after the last write
        out_ready = 1'b1;
        send(0, 16);
        check("lat_valid_lo", out_valid, 0);
        tick();
        check("lat_valid_hi", out_valid, 1);
        recv(0, 1, 1'b0, cyc);
        check("single_cycles", cyc, 16);
        check("single_idle", out_valid, 0);

        // Four back-to-back frames, no bubble between frames
        fork
            send_frames(1, 4);
            recv(1, 4, 1'b0, cyc);
        join
        check("b2b_cycles", cyc, 64);
        check("b2b_idle", out_valid, 0);
        check("b2b_overflow", err_overflow, 0);
        check("b2b_resync", err_resync, 0);

        // Output stalls with ready pattern 1,0,0,1
        fork
            send_frames(10, 2);
            recv(10, 2, 1'b1, cyc);
        join
        check("stall_idle", out_valid, 0);
        check("stall_overflow", err_overflow, 0);

        // Overflow: three frames while the output is blocked
        out_ready = 1'b0;
        send_frames(20, 3);
        check("ovf_flag", err_overflow, 1);
        check("ovf_resync", err_resync, 0);
        check("ovf_hold_valid", out_valid, 1);
        check("ovf_hold_data", out_data, mk(20, 0));
        recv(20, 2, 1'b0, cyc);
        check("ovf_cycles", cyc, 32);
        repeat (4) tick();
        check("ovf_third_dropped", out_valid, 0);
        send(23, 16);
        recv(23, 1, 1'b0, cyc);
        check("ovf_sticky", err_overflow, 1);

        // Resync: in_first arrives at input position 7
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rsy_ovf_cleared", err_overflow, 0);
        send(30, 7);
        send(31, 16);
        recv(31, 1, 1'b0, cyc);
        check("rsy_flag", err_resync, 1);
        check("rsy_overflow", err_overflow, 0);
        repeat (20) tick();
        check("rsy_only_restart", out_valid, 0);

        // Reset pulsed during drain
        send(40, 16);
        repeat (6) tick();
        check("mid_valid_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_valid_async", out_valid, 0);
        check("mid_first_async", out_first, 0);
        check("mid_resync_cleared", err_resync, 0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("mid_empty", out_valid, 0);
        send(41, 16);
        recv(41, 1, 1'b0, cyc);
        check("mid_after_overflow", err_overflow, 0);
        check("mid_after_resync", err_resync, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
